// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Read data returned when a transfer is terminated by the timeout.
  localparam logic [31:0] APB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready request into an APB SETUP/ACCESS transfer
// and returns the result on a valid/ready response channel. A per-transfer
// ACCESS-cycle counter terminates transfers to slaves that never raise PREADY.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  // Count value seen on the last ACCESS cycle allowed before forced termination.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  // Saturating increment: the counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A new request may enter only from IDLE, and only if the response slot is free or draining.
  assign req_ready   = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Next-state and next-output computation for the transfer FSM and response slot.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY takes priority over a timeout falling on the same cycle.
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          rsp_rdata_d = DATA_W'(APB_ERR_DATA);
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset also aborts any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level reference model plus directed and random traffic.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 3;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Requester / slave / reset controls set by the scenarios.
  bit          r_valid, r_write, rr, rst;
  logic [31:0] r_addr, r_wdata, r_prdata;
  int          r_w;

  // Reference model: one transfer in flight, described by cycles since accept (k),
  // number of ACCESS cycles it will take (a) and the slave's wait count (w).
  bit          m_busy, m_pwrite, m_rv, m_re;
  int          m_k, m_a, c_w;
  logic [31:0] m_paddr, m_pwdata, c_prdata, m_rd;

  // Observations of the DUT used for literal checks.
  int          t_acc, t_psel, t_pen, t_rsp, n_acc;
  logic [31:0] o_rd;
  logic        o_err;
  bit          acc_flag;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // One clock: drive inputs, check req_ready, advance model, check registered outputs.
  task automatic step();
    bit exp_rdy;
    bit acc;
    PRESET    = rst;
    req_valid = r_valid;
    req_write = r_write;
    req_addr  = r_addr;
    req_wdata = r_wdata;
    rsp_ready = rr;
    if (m_busy && m_k >= 2) begin
      PREADY = ((m_k - 2) == c_w);
      PRDATA = ((m_k - 2) == c_w) ? c_prdata : $urandom();
    end else begin
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom();
    end
    exp_rdy = !m_busy && (!m_rv || rr);
    #1;
    chk("req_ready", req_ready, exp_rdy);
    @(posedge PCLK);
    cyc++;
    acc = !rst && r_valid && exp_rdy;
    acc_flag = acc;
    if (rst) begin
      m_busy = 0; m_rv = 0; m_re = 0; m_rd = '0;
      m_paddr = '0; m_pwdata = '0; m_pwrite = 0; m_k = 0;
    end else begin
      if (m_rv && rr) m_rv = 0;
      if (m_busy) begin
        m_k++;
        if (m_k == m_a + 2) begin
          m_busy = 0;
          m_rv   = 1;
          if (c_w < TO) begin
            m_rd = m_pwrite ? 32'h0 : c_prdata;
            m_re = 0;
          end else begin
            m_rd = 32'hDEADBEEF;
            m_re = 1;
          end
        end
      end else if (acc) begin
        m_busy   = 1;
        m_k      = 1;
        m_paddr  = r_addr;
        m_pwrite = r_write;
        m_pwdata = r_wdata;
        c_w      = r_w;
        c_prdata = r_prdata;
        m_a      = (r_w + 1 < TO) ? r_w + 1 : TO;
        r_valid  = 0;
      end
    end
    #1;
    chk("PSEL", PSEL, m_busy);
    chk("PENABLE", PENABLE, m_busy && m_k >= 2);
    chk("PADDR", PADDR, m_paddr);
    chk("PWRITE", PWRITE, m_pwrite);
    chk("PWDATA", PWDATA, m_pwdata);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv) begin
      chk("rsp_rdata", rsp_rdata, m_rd);
      chk("rsp_err", rsp_err, m_re);
    end
    if (acc) begin
      t_acc = cyc - 1; t_psel = -1; t_pen = -1; t_rsp = -1; n_acc = 0;
    end
    if (PSEL && t_psel < 0) t_psel = cyc;
    if (PENABLE) begin
      if (t_pen < 0) t_pen = cyc;
      n_acc++;
    end
    if (rsp_valid && !PSEL && t_pen >= 0 && t_rsp < 0) begin
      t_rsp = cyc; o_rd = rsp_rdata; o_err = rsp_err;
    end
  endtask

  task automatic wait_rsp(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (t_rsp >= 0) return;
      step();
    end
    bound_fail(nm);
  endtask

  task automatic run_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int w, input logic [31:0] pd, input string nm);
    r_write = wr; r_addr = a; r_wdata = wd; r_w = w; r_prdata = pd; r_valid = 1;
    t_rsp = -1; t_pen = -1;
    wait_rsp(nm);
  endtask

  initial begin
    int acc_t[$];
    logic [31:0] rd_q[$];
    int burst;

    rst = 1; rr = 1; r_valid = 0; r_write = 0; r_addr = '0; r_wdata = '0; r_prdata = '0; r_w = 0;
    t_acc = -1; t_psel = -1; t_pen = -1; t_rsp = -1; n_acc = 0;
    step(); step();
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    rst = 0;
    step();

    // Zero-wait read.
    run_req(0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, "zw_bound");
    chk("zw_psel_lat", t_psel - t_acc, 1);
    chk("zw_pen_lat", t_pen - t_acc, 2);
    chk("zw_rsp_lat", t_rsp - t_acc, 3);
    chk("zw_rdata", o_rd, 32'h1234_5678);
    chk("zw_err", o_err, 1'b0);
    step();

    // Write with three wait states: PREADY arrives on the 4th ACCESS cycle.
    run_req(1, 32'h0000_0004, 32'hA5A5_A5A5, 3, 32'hFFFF_0000, "ws_bound");
    chk("ws_access_cycles", n_acc, 4);
    chk("ws_rsp_lat", t_rsp - t_acc, 6);
    chk("ws_rdata", o_rd, 32'h0);
    chk("ws_err", o_err, 1'b0);
    step();

    // Slave never ready: timeout after exactly four ACCESS cycles.
    run_req(0, 32'h0000_0020, 32'h0, 99, 32'h0, "to_bound");
    chk("to_access_cycles", n_acc, 4);
    chk("to_psel", PSEL, 1'b0);
    chk("to_rdata", o_rd, 32'hDEADBEEF);
    chk("to_err", o_err, 1'b1);
    step();

    // Response backpressure blocks the next accept until rsp_ready returns.
    rr = 0;
    run_req(0, 32'h0000_0030, 32'h0, 0, 32'h0000_55AA, "bp_bound");
    r_write = 0; r_addr = 32'h0000_0040; r_w = 0; r_prdata = 32'h0BAD_F00D; r_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_psel", PSEL, 1'b0);
      chk("bp_rsp_hold", rsp_rdata, 32'h0000_55AA);
    end
    rr = 1;
    step();
    chk("bp_accept_psel", PSEL, 1'b1);
    chk("bp_accept_paddr", PADDR, 32'h0000_0040);
    chk("bp_drained", rsp_valid, 1'b0);
    wait_rsp("bp2_bound");
    chk("bp2_rdata", o_rd, 32'h0BAD_F00D);

    // Three back-to-back zero-wait reads.
    step();
    r_write = 0; r_addr = 32'h100; r_w = 0; r_prdata = 32'hC0DE_0001; r_valid = 1;
    burst = 1;
    for (int i = 0; i < 30 && rd_q.size() < 3; i++) begin
      step();
      if (acc_flag) begin
        acc_t.push_back(cyc);
        if (burst < 3) begin
          r_addr = 32'h100 + 32'(burst * 4); r_prdata = 32'hC0DE_0001 + 32'(burst);
          r_valid = 1; burst++;
        end
      end
      if (rsp_valid) rd_q.push_back(rsp_rdata);
    end
    if (rd_q.size() == 3 && acc_t.size() == 3) begin
      chk("b2b_gap1", acc_t[1] - acc_t[0], 3);
      chk("b2b_gap2", acc_t[2] - acc_t[1], 3);
      chk("b2b_rd0", rd_q[0], 32'hC0DE_0001);
      chk("b2b_rd1", rd_q[1], 32'hC0DE_0002);
      chk("b2b_rd2", rd_q[2], 32'hC0DE_0003);
    end else begin
      bound_fail("b2b_count");
    end

    // Reset while in ACCESS aborts the transfer without a response.
    step();
    r_write = 0; r_addr = 32'h200; r_w = 99; r_prdata = 32'h0; r_valid = 1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        step();
        seen = PENABLE;
      end
      if (!seen) bound_fail("rst_access_bound");
    end
    rst = 1;
    step();
    rst = 0;
    chk("ra_psel", PSEL, 1'b0);
    chk("ra_penable", PENABLE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ra_no_rsp", rsp_valid, 1'b0);
    end

    // Random traffic: waits 0..5 (some exceed the timeout), random backpressure, rare resets.
    for (int i = 0; i < 800; i++) begin
      if (!r_valid && $urandom_range(0, 2) == 0) begin
        r_write = 1'($urandom_range(0, 1));
        r_addr = $urandom(); r_wdata = $urandom(); r_prdata = $urandom();
        r_w = $urandom_range(0, 5);
        r_valid = 1;
      end
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
